// File: rtl/spi_stream_pack_fifo_if.sv
// rtl/spi_stream_pack_fifo_if.sv - sample input and host read-pipe signal bundle
interface spi_stream_pack_fifo_if #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 32,
  parameter int DEPTH  = 2048,
  parameter int DROP_W = 16
);
  logic [IN_W-1:0]          din;
  logic                     din_wen;
  logic                     rd_open;
  logic                     rd_en;
  logic [OUT_W-1:0]         rd_data;
  logic                     rd_empty;
  logic                     rd_eof;
  logic [$clog2(DEPTH):0]   fill_level;
  logic                     overflow;
  logic [DROP_W-1:0]        drop_count;

  modport master (
    output din, din_wen, rd_open, rd_en,
    input  rd_data, rd_empty, rd_eof, fill_level, overflow, drop_count
  );

  modport slave (
    input  din, din_wen, rd_open, rd_en,
    output rd_data, rd_empty, rd_eof, fill_level, overflow, drop_count
  );
endinterface

// File: rtl/spi_stream_pack_fifo.sv
// rtl/spi_stream_pack_fifo.sv - packs IN_W samples into OUT_W words behind a read-pipe FIFO
module spi_stream_pack_fifo #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 32,
  parameter int DEPTH  = 2048,
  parameter int DROP_W = 16
) (
  input  logic                  bus_clk,
  input  logic                  reset,
  spi_stream_pack_fifo_if.slave pipe
);
  localparam int R  = OUT_W / IN_W;
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int KW = (R > 1) ? $clog2(R) : 1;
  localparam logic [KW-1:0]       K_LAST = KW'(R - 1);
  localparam logic [FW-1:0]       FULL_LEVEL = FW'(DEPTH);
  localparam logic [DROP_W+2:0]   DROP_MAX = {3'b000, {DROP_W{1'b1}}};

  logic [OUT_W-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [FW-1:0]     fill;
  logic [KW-1:0]     k;
  logic [OUT_W-1:0]  pack;
  logic              overflow_q;
  logic [DROP_W-1:0] drop_q;
  logic [OUT_W-1:0]  rd_data_q;
  logic              rd_empty_q;
  logic              rd_eof_q;

  logic              clr, rd_acc, wen_ok, push_try, push_ok, push_fail, ov_n;
  logic [OUT_W-1:0]  word;
  logic [FW-1:0]     fill_n;
  logic [KW-1:0]     k_n;
  logic [2:0]        drop_inc;
  logic [DROP_W+2:0] drop_sum;
  logic [DROP_W-1:0] drop_n;

  always_comb begin
    clr       = reset | ~pipe.rd_open;
    rd_acc    = pipe.rd_en & ~rd_empty_q;
    wen_ok    = pipe.din_wen & ~overflow_q;
    push_try  = wen_ok & (k == K_LAST);
    push_ok   = push_try & ((fill != FULL_LEVEL) | rd_acc);
    push_fail = push_try & (fill == FULL_LEVEL) & ~rd_acc;
    ov_n      = overflow_q | push_fail;

    // Current sample drops into its lane of the partially built word.
    word = pack;
    word[int'(k)*IN_W +: IN_W] = pipe.din;

    k_n = k;
    if (wen_ok)
      k_n = (k == K_LAST) ? '0 : k + KW'(1);
    if (ov_n)
      k_n = '0;

    fill_n = fill + FW'(push_ok) - FW'(rd_acc);

    drop_inc = 3'd0;
    if (push_fail)
      drop_inc = 3'(R);
    else if (pipe.din_wen & overflow_q)
      drop_inc = 3'd1;
    drop_sum = {3'b000, drop_q} + {{DROP_W{1'b0}}, drop_inc};
    drop_n   = (drop_sum > DROP_MAX) ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge bus_clk) begin
    if (push_ok && !clr)
      mem[wr_ptr] <= word;
  end

  always_ff @(posedge bus_clk) begin
    if (clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      k          <= '0;
      pack       <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      rd_data_q  <= '0;
      rd_empty_q <= 1'b1;
      rd_eof_q   <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) begin
        rd_ptr    <= rd_ptr + AW'(1);
        rd_data_q <= mem[rd_ptr];
      end
      if (wen_ok)
        pack <= word;
      fill       <= fill_n;
      k          <= k_n;
      overflow_q <= ov_n;
      drop_q     <= drop_n;
      // Flags are derived from next-state values so they line up with fill_level.
      rd_empty_q <= (fill_n == '0);
      rd_eof_q   <= ov_n & (fill_n == '0) & (k_n == '0);
    end
  end

  assign pipe.rd_data    = rd_data_q;
  assign pipe.rd_empty   = rd_empty_q;
  assign pipe.rd_eof     = rd_eof_q;
  assign pipe.fill_level = fill;
  assign pipe.overflow   = overflow_q;
  assign pipe.drop_count = drop_q;
endmodule

// File: tb/tb_spi_stream_pack_fifo.sv
// tb/tb_spi_stream_pack_fifo.sv - directed plus random check against a queue model
module tb_spi_stream_pack_fifo;
  localparam int IN_W   = 16;
  localparam int OUT_W  = 32;
  localparam int DEPTH  = 4;
  localparam int DROP_W = 4;
  localparam int R      = OUT_W / IN_W;
  localparam int DMAX   = (1 << DROP_W) - 1;

  logic bus_clk = 1'b0;
  logic reset;
  always #5 bus_clk = ~bus_clk;

  spi_stream_pack_fifo_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) bus ();

  spi_stream_pack_fifo #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .bus_clk (bus_clk),
    .reset   (reset),
    .pipe    (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [OUT_W-1:0] mq[$];
  logic [IN_W-1:0]  part[$];
  bit               m_ov;
  int               m_drop;
  logic [OUT_W-1:0] m_rdd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > DMAX) ? DMAX : v;
  endfunction

  task automatic model_step();
    bit rd;
    int sz;
    logic [OUT_W-1:0] w;
    if (reset || !bus.rd_open) begin
      mq.delete();
      part.delete();
      m_ov   = 0;
      m_drop = 0;
      m_rdd  = '0;
    end else begin
      sz = mq.size();
      rd = bus.rd_en && (sz != 0);
      if (rd) begin
        m_rdd = mq[0];
        void'(mq.pop_front());
      end
      if (bus.din_wen) begin
        if (m_ov) begin
          m_drop = sat(m_drop + 1);
        end else begin
          part.push_back(bus.din);
          if (part.size() == R) begin
            w = '0;
            for (int i = 0; i < R; i++) w[i*IN_W +: IN_W] = part[i];
            if (sz < DEPTH || rd) mq.push_back(w);
            else begin
              m_ov   = 1;
              m_drop = sat(m_drop + R);
            end
            part.delete();
          end
        end
      end
    end
  endtask

  task automatic check_model();
    check("rd_data", bus.rd_data, m_rdd);
    check("rd_empty", bus.rd_empty, mq.size() == 0);
    check("fill_level", bus.fill_level, mq.size());
    check("overflow", bus.overflow, m_ov);
    check("drop_count", bus.drop_count, m_drop);
    check("rd_eof", bus.rd_eof, m_ov && mq.size() == 0 && part.size() == 0);
  endtask

  task automatic step(input logic [IN_W-1:0] d, input logic w, input logic r,
                      input logic o, input logic rst);
    bus.din     = d;
    bus.din_wen = w;
    bus.rd_en   = r;
    bus.rd_open = o;
    reset       = rst;
    @(posedge bus_clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic wr(input logic [IN_W-1:0] d);
    step(d, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic rd();
    step('0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic close1();
    step('0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.din = '0; bus.din_wen = 1'b0; bus.rd_en = 1'b0; bus.rd_open = 1'b0; reset = 1'b1;

    step('0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_empty", bus.rd_empty, 1'b1);
    check("reset_fill", bus.fill_level, 0);
    check("reset_data", bus.rd_data, 0);

    // Ordering with two lanes per word
    wr(16'h1111);
    check("t1_empty_after1", bus.rd_empty, 1'b1);
    wr(16'h2222);
    check("t1_empty_after2", bus.rd_empty, 1'b0);
    check("t1_fill1", bus.fill_level, 1);
    wr(16'h3333);
    wr(16'h4444);
    check("t1_fill2", bus.fill_level, 2);
    rd();
    check("t1_word0", bus.rd_data, 32'h22221111);
    check("t1_fill3", bus.fill_level, 1);
    rd();
    check("t1_word1", bus.rd_data, 32'h44443333);
    check("t1_fill4", bus.fill_level, 0);

    // Fill, overflow, drop counting, eof
    close1();
    for (int i = 0; i < 8; i++) wr(16'h0100 + 16'(i));
    check("t2_full", bus.fill_level, 4);
    wr(16'h0108);
    wr(16'h0109);
    check("t2_ovf", bus.overflow, 1'b1);
    check("t2_drop2", bus.drop_count, 2);
    for (int i = 0; i < 3; i++) wr(16'h0200);
    check("t2_drop5", bus.drop_count, 5);
    for (int i = 0; i < 3; i++) rd();
    check("t2_no_eof_yet", bus.rd_eof, 1'b0);
    rd();
    check("t2_last_word", bus.rd_data, 32'h01070106);
    check("t2_eof", bus.rd_eof, 1'b1);

    // Push into full FIFO coinciding with a read
    close1();
    for (int i = 0; i < 9; i++) wr(16'h0A00 + 16'(i));
    step(16'h0A09, 1'b1, 1'b1, 1'b1, 1'b0);
    check("t3_no_ovf", bus.overflow, 1'b0);
    check("t3_fill", bus.fill_level, 4);
    check("t3_head", bus.rd_data, 32'h0A010A00);
    for (int i = 0; i < 4; i++) rd();
    check("t3_wrap_word", bus.rd_data, 32'h0A090A08);

    // Read while empty
    rd();
    check("t4_hold", bus.rd_data, 32'h0A090A08);
    check("t4_fill", bus.fill_level, 0);
    wr(16'hBEEF);
    wr(16'hCAFE);
    rd();
    check("t4_pair", bus.rd_data, 32'hCAFEBEEF);

    // Close mid-word, then mid-overflow
    wr(16'h5555);
    close1();
    check("t5_fill", bus.fill_level, 0);
    check("t5_drop", bus.drop_count, 0);
    wr(16'hAAAA);
    wr(16'hBBBB);
    rd();
    check("t5_lane0", bus.rd_data, 32'hBBBBAAAA);
    for (int i = 0; i < 10; i++) wr(16'h0300 + 16'(i));
    close1();
    check("t5_ovf_cleared", bus.overflow, 1'b0);

    // Saturating drop counter, then reset pulse
    for (int i = 0; i < 10; i++) wr(16'h0400 + 16'(i));
    for (int i = 0; i < 20; i++) wr(16'h0500);
    check("t6_sat", bus.drop_count, 15);
    step('0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("t6_rst_drop", bus.drop_count, 0);
    check("t6_rst_ovf", bus.overflow, 1'b0);
    check("t6_rst_empty", bus.rd_empty, 1'b1);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step(16'($urandom), 1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 4),
           1'($urandom_range(0, 63) != 0), 1'($urandom_range(0, 127) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
